// File: rtl/cordic_sqrt_pkg.sv
// Shared constants and helpers for the cordic_sqrt_seq datapath blocks.
package cordic_sqrt_pkg;

  localparam int ISQRT_BW_RAD_DEFAULT = 8;
  localparam int ISQRT_BW_CNT_DEFAULT = 3;

  // Ceiling log2 for deriving counter widths at integration time.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit: trial-subtract {root,01} from the
// extended remainder and keep the difference when it does not borrow.
module isqrt_step #(
  parameter int BW_RAD = 8
) (
  input  logic [BW_RAD/2:0]   rem_i,
  input  logic [BW_RAD/2-1:0] root_i,
  input  logic [1:0]          rad_bits_i,
  output logic [BW_RAD/2:0]   rem_o,
  output logic                root_bit_o
);

  localparam int H = BW_RAD / 2;

  logic [H+2:0] r2_s;
  logic [H+2:0] trial_s;
  logic [H+2:0] diff_s;
  logic         unused_bits_s;

  assign r2_s    = {rem_i, rad_bits_i};
  assign trial_s = {1'b0, root_i, 2'b01};
  assign diff_s  = r2_s - trial_s;

  // r2 stays below 2**(H+2), so the MSB of the difference is a clean borrow.
  always_comb begin
    rem_o      = r2_s[H:0];
    root_bit_o = 1'b0;
    if (diff_s[H+2] == 1'b0) begin
      rem_o      = diff_s[H:0];
      root_bit_o = 1'b1;
    end else begin
      rem_o      = r2_s[H:0];
      root_bit_o = 1'b0;
    end
  end

  // Upper bits are provably zero once the remainder is stored.
  assign unused_bits_s = ^{diff_s[H+1], r2_s[H+2:H+1]};

endmodule

// File: rtl/seq_isqrt.sv
// Sequential restoring integer square root, one root bit per clock, with the
// clear/start/busy handshake of the upstream multiplier plus a done pulse.
module seq_isqrt
  import cordic_sqrt_pkg::*;
#(
  parameter int BW_RAD = ISQRT_BW_RAD_DEFAULT,
  parameter int BW_CNT = ISQRT_BW_CNT_DEFAULT
) (
  input  logic                clk,
  input  logic                rstx,
  input  logic                clear,
  input  logic                start,
  input  logic                rad_is_signed,
  input  logic [BW_RAD-1:0]   rad,
  output logic [BW_RAD/2-1:0] root,
  output logic [BW_RAD/2:0]   rem,
  output logic                busy,
  output logic                done,
  output logic                neg
);

  localparam int BW_ROOT = BW_RAD / 2;
  localparam logic [BW_CNT-1:0] CNT_ZERO = {BW_CNT{1'b0}};
  localparam logic [BW_CNT-1:0] CNT_ONE  = {{(BW_CNT-1){1'b0}}, 1'b1};
  localparam logic [BW_CNT-1:0] CNT_ITER = BW_CNT'(BW_ROOT);

  logic [BW_CNT-1:0]  cnt_q,  cnt_d;
  logic [BW_ROOT-1:0] root_q, root_d;
  logic [BW_ROOT:0]   rem_q,  rem_d;
  logic [BW_RAD-1:0]  sr_q,   sr_d;
  logic               neg_q,  neg_d;
  logic               done_q, done_d;

  logic [BW_ROOT:0]   step_rem_s;
  logic               step_bit_s;
  logic               rad_neg_s;

  assign rad_neg_s = rad_is_signed & rad[BW_RAD-1];

  isqrt_step #(
    .BW_RAD(BW_RAD)
  ) u_step (
    .rem_i      (rem_q),
    .root_i     (root_q),
    .rad_bits_i (sr_q[BW_RAD-1:BW_RAD-2]),
    .rem_o      (step_rem_s),
    .root_bit_o (step_bit_s)
  );

  // Next-state: clear beats start beats iterate; otherwise hold.
  always_comb begin
    cnt_d  = cnt_q;
    root_d = root_q;
    rem_d  = rem_q;
    sr_d   = sr_q;
    neg_d  = neg_q;
    done_d = 1'b0;
    if (clear) begin
      cnt_d  = CNT_ZERO;
      root_d = {BW_ROOT{1'b0}};
      rem_d  = {(BW_ROOT+1){1'b0}};
      neg_d  = 1'b0;
      done_d = 1'b0;
    end else if (start) begin
      root_d = {BW_ROOT{1'b0}};
      rem_d  = {(BW_ROOT+1){1'b0}};
      sr_d   = rad;
      if (rad_neg_s) begin
        neg_d  = 1'b1;
        cnt_d  = CNT_ZERO;
        done_d = 1'b1;
      end else begin
        neg_d  = 1'b0;
        cnt_d  = CNT_ITER;
        done_d = 1'b0;
      end
    end else if (cnt_q != CNT_ZERO) begin
      rem_d  = step_rem_s;
      root_d = {root_q[BW_ROOT-2:0], step_bit_s};
      sr_d   = {sr_q[BW_RAD-3:0], 2'b00};
      cnt_d  = cnt_q - CNT_ONE;
      done_d = (cnt_q == CNT_ONE);
    end else begin
      done_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      cnt_q  <= CNT_ZERO;
      root_q <= {BW_ROOT{1'b0}};
      rem_q  <= {(BW_ROOT+1){1'b0}};
      sr_q   <= {BW_RAD{1'b0}};
      neg_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      root_q <= root_d;
      rem_q  <= rem_d;
      sr_q   <= sr_d;
      neg_q  <= neg_d;
      done_q <= done_d;
    end
  end

  assign busy = (cnt_q != CNT_ZERO);
  assign done = done_q;
  assign root = root_q;
  assign rem  = rem_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_seq_isqrt.sv
// Scoreboard bench for seq_isqrt: expectations are queued at start and
// compared when done pulses.
module tb_seq_isqrt;

  localparam int BW_RAD = 8;
  localparam int BW_CNT = 3;
  localparam int H      = BW_RAD / 2;

  typedef struct packed {
    logic [H-1:0] root;
    logic [H:0]   rem;
    logic         neg;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstx = 1'b0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic              rad_is_signed = 1'b0;
  logic [BW_RAD-1:0] rad = '0;
  logic [H-1:0]      root;
  logic [H:0]        rem;
  logic              busy;
  logic              done;
  logic              neg;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  seq_isqrt #(
    .BW_RAD(BW_RAD),
    .BW_CNT(BW_CNT)
  ) dut (
    .clk           (clk),
    .rstx          (rstx),
    .clear         (clear),
    .start         (start),
    .rad_is_signed (rad_is_signed),
    .rad           (rad),
    .root          (root),
    .rem           (rem),
    .busy          (busy),
    .done          (done),
    .neg           (neg)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] v, input logic s);
    exp_t e;
    int   r;
    e = '0;
    if (s && v[7]) begin
      e.neg = 1'b1;
      return e;
    end
    r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    e.root = 4'(r);
    e.rem  = 5'(int'(v) - r * r);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] v, input logic s);
    exp_q.push_back(model(v, s));
    rad = v;
    rad_is_signed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    rad = 8'($urandom);
    rad_is_signed = 1'($urandom);
  endtask

  task automatic wait_done(output int busy_n, output int wait_n, output bit seen);
    busy_n = 0;
    wait_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      tick();
      wait_n++;
    end
  endtask

  task automatic test_reset();
    rstx = 1'b0;
    tick();
    tick();
    checks++;
    if ({root, rem, busy, done, neg} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs root=%0d rem=%0d busy=%0b done=%0b neg=%0b expected all zero",
               root, rem, busy, done, neg);
    end
    rstx = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%0b done=%0b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int nb, nw;
    bit seen;
    exp_t e, got;
    launch(8'd144, 1'b0);
    wait_done(nb, nw, seen);
    checks++;
    if (!seen || nb != H || nw != H) begin
      failures++;
      $display("FAIL basic_latency seen=%0b busy_cycles=%0d wait=%0d expected busy_cycles=%0d wait=%0d",
               seen, nb, nw, H, H);
    end
    e = exp_q.pop_front();
    got = {root, rem, neg};
    checks++;
    if (got !== e || root !== 4'd12 || rem !== 5'd0) begin
      failures++;
      $display("FAIL basic_144 root=%0d rem=%0d neg=%0b expected root=12 rem=0 neg=0",
               root, rem, neg);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_at_done busy=%0b expected 0", busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || root !== 4'd12) begin
      failures++;
      $display("FAIL basic_pulse done=%0b root=%0d expected done=0 root=12", done, root);
    end
  endtask

  task automatic test_values();
    logic [7:0] vals[4];
    logic       sgn[4];
    int nb, nw, lat;
    bit seen;
    exp_t e, got;
    vals = '{8'd255, 8'd0, 8'h90, 8'h64};
    sgn  = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      launch(vals[k], sgn[k]);
      wait_done(nb, nw, seen);
      e = exp_q.pop_front();
      lat = e.neg ? 0 : H;
      got = {root, rem, neg};
      checks++;
      if (!seen || nb != lat || nw != lat || got !== e) begin
        failures++;
        $display("FAIL value_%0h seen=%0b busy_cycles=%0d wait=%0d root=%0d rem=%0d neg=%0b expected cycles=%0d root=%0d rem=%0d neg=%0b",
                 vals[k], seen, nb, nw, root, rem, neg, lat, e.root, e.rem, e.neg);
      end
      tick();
    end
  endtask

  task automatic test_sweep();
    int nb, nw, r, m;
    bit seen;
    exp_t e, got;
    for (int v = 0; v < 256; v++) begin
      launch(8'(v), 1'b0);
      wait_done(nb, nw, seen);
      e = exp_q.pop_front();
      got = {root, rem, neg};
      r = int'(root);
      m = int'(rem);
      checks++;
      if (!seen || got !== e || r * r + m != v || m > 2 * r) begin
        failures++;
        $display("FAIL sweep_%0d seen=%0b root=%0d rem=%0d expected root=%0d rem=%0d",
                 v, seen, root, rem, e.root, e.rem);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int nb, nw, extra;
    bit seen;
    exp_t e, got;
    exp_q.delete();
    launch(8'd200, 1'b0);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_running done=%0b busy=%0b expected 0 1", done, busy);
    end
    exp_q.delete();
    launch(8'd49, 1'b0);
    wait_done(nb, nw, seen);
    checks++;
    if (!seen || nw != H) begin
      failures++;
      $display("FAIL b2b_latency seen=%0b wait=%0d expected wait=%0d", seen, nw, H);
    end
    e = exp_q.pop_front();
    got = {root, rem, neg};
    checks++;
    if (got !== e || root !== 4'd7 || rem !== 5'd0) begin
      failures++;
      $display("FAIL b2b_result root=%0d rem=%0d expected root=7 rem=0", root, rem);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL b2b_single_done extra_done=%0d expected 0", extra);
    end
  endtask

  task automatic test_clear();
    int extra;
    exp_q.delete();
    launch(8'd99, 1'b0);
    tick();
    clear = 1'b1;
    start = 1'b1;
    rad = 8'd99;
    rad_is_signed = 1'b0;
    tick();
    clear = 1'b0;
    start = 1'b0;
    exp_q.delete();
    checks++;
    if ({busy, done, root, rem, neg} !== 12'h000) begin
      failures++;
      $display("FAIL clear_state busy=%0b done=%0b root=%0d rem=%0d neg=%0b expected all zero",
               busy, done, root, rem, neg);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL clear_no_done active_cycles=%0d expected 0", extra);
    end
  endtask

  task automatic test_async_reset();
    int nb, nw, extra;
    bit seen;
    exp_t e, got;
    launch(8'd200, 1'b0);
    tick();
    #2;
    rstx = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if ({root, rem, busy, done, neg} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset root=%0d rem=%0d busy=%0b done=%0b neg=%0b expected all zero",
               root, rem, busy, done, neg);
    end
    tick();
    rstx = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL async_reset_no_done active_cycles=%0d expected 0", extra);
    end
    launch(8'd200, 1'b0);
    wait_done(nb, nw, seen);
    e = exp_q.pop_front();
    got = {root, rem, neg};
    checks++;
    if (!seen || got !== e || root !== 4'd14 || rem !== 5'd4) begin
      failures++;
      $display("FAIL async_reset_rerun seen=%0b root=%0d rem=%0d expected root=14 rem=4",
               seen, root, rem);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_sweep();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
